// File: rtl/se_pkg.sv
`default_nettype none
// ============================================================================
// Module   : se_pkg
// Purpose  : Shared widths and the packed command record carried from the
//            host through the issue queue into the SE datapath.
// Contents : SE_INST_W, SE_DATA_W, se_cmd_t (inst, op1, op2, cond; 392 bits)
// Revision : 1.0 - initial release
// ============================================================================
package se_pkg;

  localparam int SE_INST_W = 8;
  localparam int SE_DATA_W = 128;

  typedef struct packed {
    logic [SE_INST_W-1:0] inst;
    logic [SE_DATA_W-1:0] op1;
    logic [SE_DATA_W-1:0] op2;
    logic [SE_DATA_W-1:0] cond;
  } se_cmd_t;

endpackage : se_pkg
`default_nettype wire

// File: rtl/se_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : se_cmd_fifo
// Purpose  : DEPTH-entry FIFO of se_cmd_t. Head slot is always visible on
//            o_head; storage clears to zero on reset.
// Ports    : clock, reset (sync, active-low)
//            i_push / i_data      - write one entry (ignored when full)
//            i_pop                - drop head entry (ignored when empty)
//            o_head               - current head slot contents
//            o_count              - occupancy 0..DEPTH
//            o_full / o_empty     - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module se_cmd_fifo
  import se_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_push,
  input  se_cmd_t                    i_data,
  input  logic                       i_pop,
  output se_cmd_t                    o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  se_cmd_t            mem_q [DEPTH];
  se_cmd_t            mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               do_push;
  logic               do_pop;

  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop  & ~o_empty;
  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
    if (do_push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : se_cmd_fifo
`default_nettype wire

// File: rtl/se_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : se_issue_queue
// Purpose  : Buffers host commands and offers them to the SE with a cap on
//            in-flight operations and a programmable minimum issue gap.
// Ports    : clock, reset (sync, active-low)
//            io_enq_*      - host command input handshake
//            io_in_*       - command offer to the SE (head entry)
//            io_done       - SE completion pulse
//            io_pace       - minimum issue gap, sampled on issue
//            io_count      - FIFO occupancy
//            io_outstanding- issued but not yet completed operations
//            io_err        - sticky completion-underflow flag
// Revision : 1.0 - initial release
// ============================================================================
module se_issue_queue
  import se_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_enq_valid,
  output logic                         io_enq_ready,
  input  logic [SE_INST_W-1:0]         io_enq_inst,
  input  logic [SE_DATA_W-1:0]         io_enq_op1,
  input  logic [SE_DATA_W-1:0]         io_enq_op2,
  input  logic [SE_DATA_W-1:0]         io_enq_cond,
  output logic                         io_in_valid,
  input  logic                         io_in_ready,
  output logic [SE_INST_W-1:0]         io_in_inst,
  output logic [SE_DATA_W-1:0]         io_in_op1,
  output logic [SE_DATA_W-1:0]         io_in_op2,
  output logic [SE_DATA_W-1:0]         io_in_cond,
  input  logic                         io_done,
  input  logic [7:0]                   io_pace,
  output logic [$clog2(DEPTH+1)-1:0]   io_count,
  output logic [$clog2(MAX_OUT+1)-1:0] io_outstanding,
  output logic                         io_err
);

  localparam int OUT_W = $clog2(MAX_OUT+1);

  se_cmd_t          enq_cmd;
  se_cmd_t          head_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue_fire;
  logic [7:0]       pace_cntr_q, pace_cntr_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             err_q, err_d;

  assign enq_cmd = '{inst: io_enq_inst, op1: io_enq_op1, op2: io_enq_op2, cond: io_enq_cond};

  se_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (io_enq_valid),
    .i_data  (enq_cmd),
    .i_pop   (issue_fire),
    .o_head  (head_cmd),
    .o_count (io_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Offer depends on registers only. Once raised it cannot drop before the
  // issue: the FIFO only pops on fire, outstanding can only fall without a
  // fire, and the pace counter stays at zero until the next fire reloads it.
  assign io_enq_ready = ~fifo_full;
  assign io_in_valid  = ~fifo_empty & (outstanding_q < OUT_W'(MAX_OUT)) & (pace_cntr_q == 8'd0);
  assign issue_fire   = io_in_valid & io_in_ready;

  assign io_in_inst     = head_cmd.inst;
  assign io_in_op1      = head_cmd.op1;
  assign io_in_op2      = head_cmd.op2;
  assign io_in_cond     = head_cmd.cond;
  assign io_outstanding = outstanding_q;
  assign io_err         = err_q;

  always_comb begin
    pace_cntr_d   = pace_cntr_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;

    if (issue_fire) begin
      pace_cntr_d = io_pace;
    end else if (pace_cntr_q != 8'd0) begin
      pace_cntr_d = pace_cntr_q - 8'd1;
    end

    case ({issue_fire, io_done})
      2'b10: outstanding_d = outstanding_q + OUT_W'(1);
      2'b01: begin
        // A completion with nothing in flight is an underflow: hold at zero.
        if (outstanding_q == '0) begin
          err_d = 1'b1;
        end else begin
          outstanding_d = outstanding_q - OUT_W'(1);
        end
      end
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pace_cntr_q   <= 8'd0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      pace_cntr_q   <= pace_cntr_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

endmodule : se_issue_queue
`default_nettype wire

// File: doc/se_issue_queue.md
# se_issue_queue

Command issue stage that sits directly upstream of the SE datapath. It buffers host commands (instruction plus three 128-bit operands) in a small FIFO and presents them to the SE `io_in_*` handshake. Issue is gated by two limits: a cap on in-flight operations (tracked from SE completions) and a programmable minimum spacing between issues. Fixed pacing gives the SE a constant, data-independent issue cadence for self-composition timing checks.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; must be a power of 2, at least 2.
- `MAX_OUT`, 2: maximum number of commands issued but not yet completed; at least 1.

Ports:
- `clock`, in, 1: sole clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-low. 0 at a rising edge resets all state.
- `io_enq_valid`, in, 1: host command valid.
- `io_enq_ready`, out, 1: queue can accept a command.
- `io_enq_inst`, in, 8: host instruction.
- `io_enq_op1`, `io_enq_op2`, `io_enq_cond`, in, 128 each: host operands.
- `io_in_valid`, out, 1: command offered to SE.
- `io_in_ready`, in, 1: SE accepts the command.
- `io_in_inst`, out, 8: head-entry instruction.
- `io_in_op1`, `io_in_op2`, `io_in_cond`, out, 128 each: head-entry operands.
- `io_done`, in, 1: one-cycle completion pulse, equal to SE `io_out_valid & io_out_ready`.
- `io_pace`, in, 8: minimum issue gap P, sampled when an issue fires.
- `io_count`, out, $clog2(DEPTH+1): FIFO occupancy.
- `io_outstanding`, out, $clog2(MAX_OUT+1): number of in-flight operations.
- `io_err`, out, 1: sticky completion-underflow flag.

## Operation
- **Enqueue** fires when `io_enq_valid & io_enq_ready`. `io_enq_ready = (count != DEPTH)`. It is registered-state-only and never depends on dequeue in the same cycle.
- **Issue** fires when `io_in_valid & io_in_ready`, then pops the head entry. `io_in_valid = !empty & (outstanding < MAX_OUT) & (pace_cntr == 0)`. It is a function of registers only and never depends on `io_in_ready`.
- **Head data:** `io_in_*` always drive the head slot. Storage resets to 0, so all `io_in_*` read 0 after reset.
- **Stability:** once `io_in_valid` rises, it and the head data stay stable until the issue fires. Pacing and the outstanding count cannot revoke a pending offer.
- **Pace counter** (8-bit):
  - Loads `io_pace` on issue fire.
  - Otherwise decrements toward 0 and saturates at 0.
  - P = 0 allows back-to-back issues.
- **Outstanding counter:**
  - +1 on issue fire.
  - −1 on `io_done`.
  - Both in the same cycle leaves it unchanged.
- **Completion underflow:** `io_done` with outstanding = 0 and no issue that cycle leaves the counter at 0 and sets `io_err` (sticky until reset).
- **Occupancy:** enqueue and issue in the same cycle leave `io_count` unchanged.
- **Pointers:** read and write pointers wrap modulo DEPTH.
- **Reset values:** `io_enq_ready` = 1; `io_in_valid` = 0; all `io_in_*` data = 0; `io_count` = 0; `io_outstanding` = 0; `io_err` = 0; pace_cntr = 0.
- **Reset mid-operation:** flushes the FIFO and drops all queued commands. The outstanding count returns to 0; later `io_done` pulses from operations issued before reset set `io_err`.

## Timing
- **Enqueue to offer:** minimum 1 cycle. A command enqueued at edge t can be offered (`io_in_valid` = 1) in the cycle after t. There is no same-cycle bypass.
- **Issue spacing:** with P = `io_pace` sampled at issue edge t, the next issue can fire no earlier than edge t+P+1.
- **Full queue:** `io_enq_ready` = 0 in the cycle after the DEPTH-th enqueue. It returns to 1 in the cycle after an issue fires.
- **Outstanding cap:** at outstanding = MAX_OUT, `io_in_valid` = 0. An `io_done` at edge t re-enables `io_in_valid` in the cycle after t.
- **Counters:** `io_count` and `io_outstanding` are registered and reflect events up to the previous edge.

## Structure
- Package `se_pkg` holds:
  - constants `SE_INST_W` = 8 and `SE_DATA_W` = 128;
  - typedef `se_cmd_t` (inst, op1, op2, cond; 392 bits packed).
- Sub-module `se_cmd_fifo` contains storage, pointers, count and full/empty for `se_cmd_t`.
- The top level holds the pace counter, outstanding counter, error flag and issue gating.

## Test plan
- **Basic issue:** enqueue one command (inst=0x11, op1=1, op2=2, cond=0) with P=0 and `io_in_ready` held high → `io_in_valid` is high for exactly 1 cycle, in the cycle after the enqueue, with matching data; `io_outstanding` = 1.
- **Fill and hold:** enqueue 5 commands with `io_in_ready` = 0 and DEPTH=4 → the 5th enqueue is refused (`io_enq_ready` = 0), `io_count` = 4. Then set `io_in_ready` = 1 with `io_done` pulsed after each issue → the 4 commands issue in FIFO order, data intact.
- **Pacing:** 3 queued commands, P=3, `io_in_ready` = 1, outstanding kept below the cap → issues fire exactly 4 cycles apart. With P=0 they fire back-to-back.
- **Outstanding cap:** MAX_OUT=2, no `io_done` → exactly 2 issues, then `io_in_valid` = 0. Pulse `io_done` at edge t → the 3rd issue fires in the cycle after t.
- **Simultaneous events:** issue fire and `io_done` at the same edge → `io_outstanding` unchanged. Enqueue and issue at the same edge → `io_count` unchanged.
- **Error and reset:** `io_done` with outstanding = 0 → `io_err` = 1 and stays set. Drive `reset` = 0 for one edge with 3 entries queued → all outputs take their reset values and the queued entries never issue.
